// File: rtl/audio_dac_i2s_tx.sv
// audio_dac_i2s_tx
// I2S transmitter for the codec DAC path. Runs entirely in the audio PLL
// output clock domain and derives BCLK and DACLRCK from it. Stereo pairs
// arrive through a valid/ready handshake into a one-deep holding register
// and are shifted out MSB-first with the I2S one-BCLK data delay.
//
// Ports:
//   refclk          in   audio master clock (single clock domain)
//   rst             in   synchronous reset, active-high
//   locked          in   PLL lock status, asynchronous (2-flop synchronised)
//   sample_valid    in   stereo pair offered
//   sample_left     in   left sample, two's complement
//   sample_right    in   right sample, two's complement
//   sample_ready    out  holding register can accept a pair
//   aud_bclk        out  codec bit clock
//   aud_daclrck     out  codec word clock (0 = left, 1 = right)
//   aud_dacdat      out  serial DAC data
//   underrun        out  one-cycle pulse: frame started with no pair held
//   running         out  serialiser active
//   underrun_count  out  saturating underrun counter (only with
//                        AUDIO_DAC_UNDERRUN_CNT_EN defined)
//
// Optional feature macro: AUDIO_DAC_UNDERRUN_CNT_EN
module audio_dac_i2s_tx #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned BCLK_DIV   = 6,
    parameter int unsigned SLOT_BITS  = 32
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_left,
    input  logic [DATA_WIDTH-1:0] sample_right,
    output logic                  sample_ready,
    output logic                  aud_bclk,
    output logic                  aud_daclrck,
    output logic                  aud_dacdat,
    output logic                  underrun,
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    output logic                  running,
    output logic [15:0]           underrun_count
`else
    output logic                  running
`endif
);

    localparam int unsigned DCNT_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned BCNT_W = $clog2(2 * SLOT_BITS);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(BCLK_DIV - 1);
    localparam logic [DCNT_W-1:0] DCNT_HALF = DCNT_W'(BCLK_DIV / 2);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(2 * SLOT_BITS - 1);
    localparam logic [BCNT_W-1:0] BCNT_SLOT = BCNT_W'(SLOT_BITS);
    localparam logic [BCNT_W-1:0] P_LAST    = BCNT_W'(DATA_WIDTH);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                state_q, state_d;
    logic                  lock_meta_q, lock_s_q;
    logic [DCNT_W-1:0]     dcnt_q, dcnt_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic                  bclk_q, bclk_d;
    logic                  lrck_q, lrck_d;
    logic                  dat_q, dat_d;
    logic                  underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0] sr_l_q, sr_l_d;
    logic [DATA_WIDTH-1:0] sr_r_q, sr_r_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic                  hold_full_q, hold_full_d;

    logic                  fall;
    logic                  flush;
    logic                  load;
    logic                  accept;
    logic [BCNT_W-1:0]     p;

    assign sample_ready = !hold_full_q && !rst;
    assign running      = (state_q == S_RUN);
    assign aud_bclk     = bclk_q;
    assign aud_daclrck  = lrck_q;
    assign aud_dacdat   = dat_q;
    assign underrun     = underrun_q;

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        bcnt_d      = bcnt_q;
        bclk_d      = bclk_q;
        lrck_d      = lrck_q;
        dat_d       = dat_q;
        sr_l_d      = sr_l_q;
        sr_r_d      = sr_r_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        underrun_d  = 1'b0;
        fall        = 1'b0;
        flush       = 1'b0;
        load        = 1'b0;
        p           = '0;
        accept      = sample_valid && sample_ready;

        case (state_q)
            S_IDLE: begin
                dcnt_d = '0;
                bcnt_d = '0;
                bclk_d = 1'b0;
                lrck_d = 1'b0;
                dat_d  = 1'b0;
                sr_l_d = '0;
                sr_r_d = '0;
                if (lock_s_q) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                if (!lock_s_q) begin
                    state_d     = S_IDLE;
                    flush       = 1'b1;
                    dcnt_d      = '0;
                    bcnt_d      = '0;
                    bclk_d      = 1'b0;
                    lrck_d      = 1'b0;
                    dat_d       = 1'b0;
                    sr_l_d      = '0;
                    sr_r_d      = '0;
                    hold_l_d    = '0;
                    hold_r_d    = '0;
                    hold_full_d = 1'b0;
                end else begin
                    if (dcnt_q == DCNT_LAST) begin
                        dcnt_d = '0;
                        fall   = 1'b1;
                        bcnt_d = (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                    bclk_d = (dcnt_d >= DCNT_HALF);
                    // Data and word clock move only on the BCLK falling edge;
                    // position 0 of each slot is the I2S delay bit.
                    if (fall) begin
                        lrck_d = (bcnt_d >= BCNT_SLOT);
                        p      = lrck_d ? (bcnt_d - BCNT_SLOT) : bcnt_d;
                        dat_d  = 1'b0;
                        if ((p != '0) && (p <= P_LAST)) begin
                            if (lrck_d) begin
                                {dat_d, sr_r_d} = {sr_r_q, 1'b0};
                            end else begin
                                {dat_d, sr_l_d} = {sr_l_q, 1'b0};
                            end
                        end
                        if (bcnt_d == '0) begin
                            load = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            if (hold_full_q) begin
                sr_l_d      = hold_l_q;
                sr_r_d      = hold_r_q;
                hold_full_d = 1'b0;
            end else begin
                sr_l_d     = '0;
                sr_r_d     = '0;
                underrun_d = 1'b1;
            end
        end

        // accept implies the holding register was empty, so it never
        // collides with a load from the holding register.
        if (accept && !flush) begin
            hold_l_d    = sample_left;
            hold_r_d    = sample_right;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            dcnt_q      <= '0;
            bcnt_q      <= '0;
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            dat_q       <= 1'b0;
            underrun_q  <= 1'b0;
            sr_l_q      <= '0;
            sr_r_q      <= '0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_meta_q <= locked;
            lock_s_q    <= lock_meta_q;
            dcnt_q      <= dcnt_d;
            bcnt_q      <= bcnt_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            dat_q       <= dat_d;
            underrun_q  <= underrun_d;
            sr_l_q      <= sr_l_d;
            sr_r_q      <= sr_r_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
        end
    end

`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    // Cleared by reset only; survives loss of lock.
    always_ff @(posedge refclk) begin
        if (rst) begin
            ucnt_q <= '0;
        end else if (underrun_d && (ucnt_q != 16'hFFFF)) begin
            ucnt_q <= ucnt_q + 16'd1;
        end
    end

    assign underrun_count = ucnt_q;
`endif

endmodule
